// File: rtl/telemetry_rx_pkg.sv
// -----------------------------------------------------------------------------
// telemetry_rx_pkg
// Shared definitions for the telemetry link. Both the receiver and the
// telemetry transmitter import this package, so the two ends agree on the
// framing.
//   pktState_e  : packet parser states (HDR1, HDR2, PAYLOAD)
//   HDR_BYTE1/2 : sync header bytes 0xAA, 0x55
//   PKT_LEN     : total packet length in bytes, header included
//   PAYLOAD_LEN : payload bytes that follow the header
//   hiByteOk()  : true when a field's hi byte carries only 4 significant bits
// -----------------------------------------------------------------------------
package telemetry_rx_pkg;

  typedef enum logic [1:0] {
    HDR1    = 2'd0,
    HDR2    = 2'd1,
    PAYLOAD = 2'd2
  } pktState_e;

  localparam logic [7:0] HDR_BYTE1   = 8'hAA;
  localparam logic [7:0] HDR_BYTE2   = 8'h55;
  localparam int         PKT_LEN     = 8;
  localparam int         PAYLOAD_LEN = PKT_LEN - 2;

  // Every 12-bit field is sent as {4'h0, field[11:8]} then field[7:0], so a
  // hi byte with anything in its upper nibble means the packet is corrupt.
  function automatic logic hiByteOk(input logic [7:0] b);
    return (b[7:4] == 4'h0);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART byte receiver with a two-flop input synchronizer.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   RX       : asynchronous serial input, idles high
//   rx_data  : last received byte, valid while rdy is high
//   rdy      : one-cycle strobe, one clock after a good stop-bit sample
//   frm_err  : one-cycle strobe when the stop bit is sampled low
// Parameter BAUD_DIV is the number of clk cycles per bit.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int CNT_W = $clog2(BAUD_DIV) + 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV);

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rxState_e;

  rxState_e         state_q;
  logic [CNT_W-1:0] baudCnt_q;
  logic [2:0]       bitCnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             rdy_q;
  logic             frmErr_q;

  logic rxMeta_q;
  logic rxSync_q;
  logic rxPrev_q;
  logic fallEdge;

  // Synchronizer flops reset to the idle level so that releasing reset can
  // never look like a start edge. rxPrev_q keeps one more sample so a falling
  // edge is seen only on the synchronized copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= RX;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  assign fallEdge = rxPrev_q & ~rxSync_q;

  // Bit-timing state machine. The counter runs from 1 so that the start bit
  // is sampled when it reaches BAUD_DIV/2 and every later bit a full
  // BAUD_DIV after the previous sample. After a good stop bit we go straight
  // back to idle, so a start edge right behind it is caught. After a bad stop
  // bit the line must be seen high again before we re-arm; otherwise a line
  // held low would restart framing on garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      frmErr_q  <= 1'b0;
    end else begin
      rdy_q    <= 1'b0;
      frmErr_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (fallEdge) begin
            state_q   <= RX_START;
            baudCnt_q <= CNT_W'(1);
          end
        end
        RX_START: begin
          if (baudCnt_q == HALF_BIT) begin
            baudCnt_q <= CNT_W'(1);
            bitCnt_q  <= '0;
            // A start bit that has already gone high was only a glitch.
            state_q   <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            baudCnt_q <= baudCnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (baudCnt_q == FULL_BIT) begin
            baudCnt_q <= CNT_W'(1);
            shift_q   <= {rxSync_q, shift_q[7:1]};
            bitCnt_q  <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              state_q <= RX_STOP;
            end
          end else begin
            baudCnt_q <= baudCnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (baudCnt_q == FULL_BIT) begin
            baudCnt_q <= '0;
            if (rxSync_q) begin
              data_q  <= shift_q;
              rdy_q   <= 1'b1;
              state_q <= RX_IDLE;
            end else begin
              frmErr_q <= 1'b1;
              state_q  <= RX_WAIT_HIGH;
            end
          end else begin
            baudCnt_q <= baudCnt_q + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rxSync_q) begin
            state_q <= RX_IDLE;
          end
        end
        default: begin
          state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_data = data_q;
  assign rdy     = rdy_q;
  assign frm_err = frmErr_q;

endmodule

// File: rtl/telemetry_rx.sv
// -----------------------------------------------------------------------------
// telemetry_rx
// Receives 8-byte telemetry packets (AA 55 battHi battLo currHi currLo
// torqHi torqLo) over a UART and publishes the three 12-bit fields from the
// most recent good packet.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   RX         : asynchronous UART input, idles high
//   batt_v     : battery voltage from the last good packet
//   avg_curr   : average current from the last good packet
//   avg_torque : average torque from the last good packet
//   pkt_vld    : one-cycle pulse when a good packet completes
//   pkt_err    : one-cycle pulse when a packet in progress is dropped
// BAUD_DIV is clk cycles per bit. TIMEOUT_BITS is the longest allowed gap,
// in bit times, between byte-ready strobes once a header has started.
// -----------------------------------------------------------------------------
module telemetry_rx
  import telemetry_rx_pkg::*;
#(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        pkt_err
);

  localparam int TIMEOUT_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TMR_W         = $clog2(TIMEOUT_LIMIT + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_LIMIT);
  localparam logic [2:0]       LAST_IDX  = 3'(PAYLOAD_LEN - 1);

  logic [7:0] rxData;
  logic       rxRdy;
  logic       rxFrmErr;

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .rx_data(rxData),
    .rdy    (rxRdy),
    .frm_err(rxFrmErr)
  );

  pktState_e        state_q;
  logic [2:0]       idx_q;
  logic [TMR_W-1:0] timer_q;

  // Shadow copies of the payload so far. Only the low nibble of each hi byte
  // is kept because the upper nibble has already been checked to be zero.
  logic [3:0]  battHi_q;
  logic [7:0]  battLo_q;
  logic [3:0]  currHi_q;
  logic [7:0]  currLo_q;
  logic [3:0]  torqHi_q;

  logic [11:0] battV_q;
  logic [11:0] avgCurr_q;
  logic [11:0] avgTorque_q;
  logic        pktVld_q;
  logic        pktErr_q;

  // Packet parser. A framing error outranks a byte strobe (the receiver
  // never raises both). The inter-byte timer runs only once a header byte
  // has been accepted and restarts on every received byte; hunting for a
  // header is never an error. The published fields change only on the
  // cycle pkt_vld is raised, so a dropped packet leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR1;
      idx_q       <= '0;
      timer_q     <= '0;
      battHi_q    <= '0;
      battLo_q    <= '0;
      currHi_q    <= '0;
      currLo_q    <= '0;
      torqHi_q    <= '0;
      battV_q     <= '0;
      avgCurr_q   <= '0;
      avgTorque_q <= '0;
      pktVld_q    <= 1'b0;
      pktErr_q    <= 1'b0;
    end else begin
      pktVld_q <= 1'b0;
      pktErr_q <= 1'b0;
      if (rxFrmErr) begin
        if (state_q != HDR1) begin
          pktErr_q <= 1'b1;
        end
        state_q <= HDR1;
        timer_q <= '0;
      end else if (rxRdy) begin
        timer_q <= '0;
        case (state_q)
          HDR1: begin
            if (rxData == HDR_BYTE1) begin
              state_q <= HDR2;
            end
          end
          HDR2: begin
            // A repeated 0xAA may be the real start of the header.
            if (rxData == HDR_BYTE2) begin
              state_q <= PAYLOAD;
              idx_q   <= '0;
            end else if (rxData != HDR_BYTE1) begin
              state_q <= HDR1;
            end
          end
          PAYLOAD: begin
            if (!idx_q[0] && !hiByteOk(rxData)) begin
              pktErr_q <= 1'b1;
              state_q  <= HDR1;
            end else begin
              idx_q <= idx_q + 3'd1;
              case (idx_q)
                3'd0:    battHi_q <= rxData[3:0];
                3'd1:    battLo_q <= rxData;
                3'd2:    currHi_q <= rxData[3:0];
                3'd3:    currLo_q <= rxData;
                3'd4:    torqHi_q <= rxData[3:0];
                default: ;
              endcase
              if (idx_q == LAST_IDX) begin
                battV_q     <= {battHi_q, battLo_q};
                avgCurr_q   <= {currHi_q, currLo_q};
                avgTorque_q <= {torqHi_q, rxData};
                pktVld_q    <= 1'b1;
                state_q     <= HDR1;
              end
            end
          end
          default: begin
            state_q <= HDR1;
          end
        endcase
      end else if (state_q != HDR1) begin
        if (timer_q == TMR_LIMIT) begin
          pktErr_q <= 1'b1;
          state_q  <= HDR1;
          timer_q  <= '0;
        end else begin
          timer_q <= timer_q + TMR_W'(1);
        end
      end else begin
        timer_q <= '0;
      end
    end
  end

  assign batt_v     = battV_q;
  assign avg_curr   = avgCurr_q;
  assign avg_torque = avgTorque_q;
  assign pkt_vld    = pktVld_q;
  assign pkt_err    = pktErr_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// -----------------------------------------------------------------------------
// tb_telemetry_rx
// Drives serial bytes into telemetry_rx and checks the published fields and
// the pkt_vld/pkt_err pulses against a byte-level packet model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_telemetry_rx;
  import telemetry_rx_pkg::*;

  localparam int BAUD_DIV     = 16;
  localparam int TIMEOUT_BITS = 16;
  localparam int N_RANDOM     = 32;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX    = 1'b1;
  logic [11:0] batt_v;
  logic [11:0] avg_curr;
  logic [11:0] avg_torque;
  logic        pkt_vld;
  logic        pkt_err;

  telemetry_rx #(
    .BAUD_DIV    (BAUD_DIV),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .batt_v    (batt_v),
    .avg_curr  (avg_curr),
    .avg_torque(avg_torque),
    .pkt_vld   (pkt_vld),
    .pkt_err   (pkt_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torq;
  } pkt_t;

  int checks      = 0;
  int fails       = 0;
  int cyc         = 0;
  int lastStopCyc = 0;
  int expVld      = 0;
  int expErr      = 0;
  int seenVld     = 0;
  int seenErr     = 0;

  logic [7:0] mbuf[$];
  logic [7:0] seqQ[$];
  pkt_t       expQ[$];
  pkt_t       lastGood = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h, required %0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic checkLiterals(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    checkOutput("batt_v literal", int'(batt_v), int'(b));
    checkOutput("avg_curr literal", int'(avg_curr), int'(c));
    checkOutput("avg_torque literal", int'(avg_torque), int'(t));
  endtask

  // Packet model: collect bytes from a header onward; drop on any rule break.
  task automatic modelByte(input logic [7:0] b);
    pkt_t p;
    if (mbuf.size() == 0) begin
      if (b == HDR_BYTE1) mbuf.push_back(b);
    end else if (mbuf.size() == 1) begin
      if (b == HDR_BYTE2) mbuf.push_back(b);
      else if (b != HDR_BYTE1) mbuf.delete();
    end else begin
      if ((mbuf.size() % 2 == 0) && (b[7:4] != 4'h0)) begin
        expErr++;
        mbuf.delete();
      end else begin
        mbuf.push_back(b);
        if (mbuf.size() == PKT_LEN) begin
          p.batt = {mbuf[2][3:0], mbuf[3]};
          p.curr = {mbuf[4][3:0], mbuf[5]};
          p.torq = {mbuf[6][3:0], mbuf[7]};
          expQ.push_back(p);
          expVld++;
          mbuf.delete();
        end
      end
    end
  endtask

  task automatic modelAbort();
    if (mbuf.size() != 0) begin
      expErr++;
      mbuf.delete();
    end
  endtask

  // Compare process: outputs must always equal the last good packet, and a
  // pkt_vld pulse must deliver the next packet the model predicted, inside
  // the stop bit of that packet's last byte.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("pkt_vld and pkt_err exclusive", int'(pkt_vld && pkt_err), 0);
      if (pkt_err) seenErr++;
      if (pkt_vld) begin
        seenVld++;
        checkOutput("pkt_vld with a pending packet", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) lastGood = expQ.pop_front();
        checkOutput("pkt_vld inside last stop bit",
                    int'((cyc - lastStopCyc) inside {[2:BAUD_DIV-1]}), 1);
      end
      checkOutput("batt_v", int'(batt_v), int'(lastGood.batt));
      checkOutput("avg_curr", int'(avg_curr), int'(lastGood.curr));
      checkOutput("avg_torque", int'(avg_torque), int'(lastGood.torq));
    end
  end

  task automatic driveBit(input logic v);
    @(negedge clk);
    RX = v;
    repeat (BAUD_DIV - 1) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopOk);
    if (stopOk) modelByte(b);
    else modelAbort();
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    @(negedge clk);
    RX = stopOk;
    lastStopCyc = cyc;
    repeat (BAUD_DIV - 1) @(negedge clk);
  endtask

  // The inter-byte timer runs from one byte-ready to the next, which spans
  // the idle gap plus the following ten-bit frame.
  task automatic idleBits(input int n);
    if ((n + 10) > TIMEOUT_BITS) modelAbort();
    @(negedge clk);
    RX = 1'b1;
    repeat (n * BAUD_DIV - 1) @(negedge clk);
  endtask

  task automatic glitch();
    @(negedge clk);
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (BAUD_DIV - 4) @(negedge clk);
  endtask

  task automatic sendSeq();
    foreach (seqQ[i]) applyStimulus(seqQ[i], 1'b1);
  endtask

  // Loopback transmitter built from the shared framing definitions.
  task automatic txPacket(input pkt_t p);
    logic [7:0] b;
    for (int i = 0; i < PKT_LEN; i++) begin
      case (i)
        0:       b = HDR_BYTE1;
        1:       b = HDR_BYTE2;
        2:       b = {4'h0, p.batt[11:8]};
        3:       b = p.batt[7:0];
        4:       b = {4'h0, p.curr[11:8]};
        5:       b = p.curr[7:0];
        6:       b = {4'h0, p.torq[11:8]};
        default: b = p.torq[7:0];
      endcase
      applyStimulus(b, 1'b1);
    end
  endtask

  task automatic endScenario(input string name);
    idleBits(3);
    checkOutput({name, " pkt_vld count"}, seenVld, expVld);
    checkOutput({name, " pkt_err count"}, seenErr, expErr);
    checkOutput({name, " packets left pending"}, expQ.size(), 0);
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    mbuf.delete();
    expQ.delete();
    lastGood = '0;
  endtask

  initial begin
    pkt_t p;
    repeat (4) @(negedge clk);
    checkLiterals(12'h000, 12'h000, 12'h000);
    checkOutput("reset pkt_vld", int'(pkt_vld), 0);
    checkOutput("reset pkt_err", int'(pkt_err), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idleBits(2);

    $display("[TB] S1 basic packet");
    seqQ = '{8'hAA, 8'h55, 8'h0A, 8'h98, 8'h01, 8'h23, 8'h04, 8'h56};
    sendSeq();
    endScenario("S1");
    checkLiterals(12'hA98, 12'h123, 12'h456);

    $display("[TB] S2 repeated header and start glitch");
    seqQ = '{8'hAA, 8'hAA, 8'h55};
    sendSeq();
    glitch();
    seqQ = '{8'h07, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'hFF};
    sendSeq();
    endScenario("S2");
    checkLiterals(12'h7FF, 12'h000, 12'hFFF);

    $display("[TB] S3 framing error in payload");
    seqQ = '{8'hAA, 8'h55, 8'h01, 8'h11, 8'h02};
    sendSeq();
    applyStimulus(8'h22, 1'b0);
    idleBits(2);
    endScenario("S3 drop");
    checkLiterals(12'h7FF, 12'h000, 12'hFFF);
    seqQ = '{8'hAA, 8'h55, 8'h0B, 8'hCD, 8'h00, 8'h01, 8'h08, 8'h00};
    sendSeq();
    endScenario("S3 recover");
    checkLiterals(12'hBCD, 12'h001, 12'h800);

    $display("[TB] S4 bad hi byte");
    seqQ = '{8'hAA, 8'h55, 8'h03, 8'h04, 8'h1A};
    sendSeq();
    endScenario("S4");
    checkLiterals(12'hBCD, 12'h001, 12'h800);

    $display("[TB] S5 inter-byte timeout");
    seqQ = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04};
    sendSeq();
    idleBits(17);
    seqQ = '{8'h05, 8'h06};
    sendSeq();
    endScenario("S5");
    checkLiterals(12'hBCD, 12'h001, 12'h800);

    $display("[TB] S6 reset mid-packet");
    seqQ = '{8'hAA, 8'h55, 8'h03, 8'h21, 8'h06, 8'h54, 8'h09, 8'h87};
    sendSeq();
    endScenario("S6 first");
    checkLiterals(12'h321, 12'h654, 12'h987);
    seqQ = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03};
    sendSeq();
    fork
      applyStimulus(8'h04, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #2 assertReset();
      end
    join
    checkLiterals(12'h000, 12'h000, 12'h000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idleBits(2);
    endScenario("S6 after reset");
    checkLiterals(12'h000, 12'h000, 12'h000);
    seqQ = '{8'hAA, 8'h55, 8'h0F, 8'hED, 8'h0C, 8'hBA, 8'h00, 8'h98};
    sendSeq();
    endScenario("S6 recover");
    checkLiterals(12'hFED, 12'hCBA, 12'h098);

    $display("[TB] S7 loopback of %0d random packets", N_RANDOM);
    for (int k = 0; k < N_RANDOM; k++) begin
      p.batt = 12'($urandom_range(0, 4095));
      p.curr = 12'($urandom_range(0, 4095));
      p.torq = 12'($urandom_range(0, 4095));
      txPacket(p);
    end
    endScenario("S7");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
